// File: rtl/labeler_pkg.sv
// Shared types for the connected-component labeler.
// Label width, label type and equivalence engine states.
package labeler_pkg;

  localparam int LABEL_WIDTH      = 8;
  localparam int NUM_LABELS       = 2**LABEL_WIDTH;
  localparam int MERGE_FIFO_DEPTH = 16;

  typedef logic [LABEL_WIDTH-1:0] label_t;

  typedef struct packed {
    label_t a;
    label_t b;
  } merge_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIND_A,
    ST_FIND_B,
    ST_LINK,
    ST_FLATTEN,
    ST_DONE
  } eng_state_t;

endpackage

// File: rtl/merge_fifo.sv
// Synchronous FIFO buffering merge requests for the union engine.
// Flush has priority over push and pop.
module merge_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= din_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/label_equiv_table.sv
// Union-find equivalence table: buffers merges, links roots,
// flattens to minimum roots at frame end and serves lookups.
module label_equiv_table
  import labeler_pkg::*;
#(
  parameter int LABEL_WIDTH      = labeler_pkg::LABEL_WIDTH,
  parameter int NUM_LABELS       = 2**LABEL_WIDTH,
  parameter int MERGE_FIFO_DEPTH = labeler_pkg::MERGE_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   new_label_valid,
  input  logic [LABEL_WIDTH-1:0] new_label_value,
  input  logic                   merge_labels,
  input  logic [LABEL_WIDTH-1:0] merge_a,
  input  logic [LABEL_WIDTH-1:0] merge_b,
  input  logic                   last_in_frame,
  output logic                   resolve_busy,
  output logic                   resolve_done,
  input  logic                   lookup_valid,
  input  logic [LABEL_WIDTH-1:0] lookup_label,
  output logic                   lookup_root_valid,
  output logic [LABEL_WIDTH-1:0] lookup_root,
  output logic                   overflow,
  output logic                   error
);

  localparam int LW = LABEL_WIDTH;

  logic [LW-1:0] parent_q [NUM_LABELS];
  eng_state_t    state_q;
  logic [LW-1:0] x_q, y_q, i_q, max_q;
  logic          pend_q, busy_q, done_q;
  logic          lv_q, ovf_q, err_q;
  logic [LW-1:0] lr_q;

  logic            acc, fs, nl_en, mg_ok, in_any;
  logic            f_full, f_empty, f_pop;
  logic [2*LW-1:0] f_dout;
  logic [LW-1:0]   pa_x, pa_y, lo, hi;

  assign acc    = !busy_q;
  assign fs     = frame_start && acc;
  assign nl_en  = new_label_valid && acc &&
                  (new_label_value != '0);
  assign mg_ok  = merge_labels && acc &&
                  (merge_a != merge_b) &&
                  (merge_a != '0) && (merge_b != '0);
  assign in_any = new_label_valid || merge_labels ||
                  last_in_frame || lookup_valid ||
                  frame_start;
  assign f_pop  = (state_q == ST_IDLE) && !f_empty;

  assign pa_x = parent_q[x_q];
  assign pa_y = parent_q[y_q];
  assign lo   = (x_q < y_q) ? x_q : y_q;
  assign hi   = (x_q < y_q) ? y_q : x_q;

  merge_fifo #(
    .WIDTH (2*LW),
    .DEPTH (MERGE_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (fs),
    .push_i  (mg_ok),
    .din_i   ({merge_a, merge_b}),
    .pop_i   (f_pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty)
  );

  // Engine and allocator share parent_q; allocation is applied last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      i_q     <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_LABELS; k++)
        parent_q[k] <= LW'(k);
    end else begin
      done_q <= 1'b0;
      if (last_in_frame && acc) begin
        pend_q <= 1'b1;
        busy_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (!f_empty) begin
            x_q     <= f_dout[2*LW-1:LW];
            y_q     <= f_dout[LW-1:0];
            state_q <= ST_FIND_A;
          end else if (pend_q) begin
            i_q     <= LW'(1);
            state_q <= ST_FLATTEN;
          end
        end
        ST_FIND_A: begin
          if (pa_x == x_q) state_q <= ST_FIND_B;
          else             x_q     <= pa_x;
        end
        ST_FIND_B: begin
          if (pa_y == y_q) state_q <= ST_LINK;
          else             y_q     <= pa_y;
        end
        ST_LINK: begin
          if (x_q != y_q) parent_q[hi] <= lo;
          state_q <= ST_IDLE;
        end
        ST_FLATTEN: begin
          if (max_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            parent_q[i_q] <= parent_q[parent_q[i_q]];
            if (i_q == max_q) state_q <= ST_DONE;
            else              i_q     <= i_q + LW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          pend_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (nl_en)
        parent_q[new_label_value] <= new_label_value;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lv_q <= 1'b0;
      lr_q <= '0;
    end else begin
      lv_q <= lookup_valid && acc;
      if (lookup_valid && acc)
        lr_q <= parent_q[lookup_label];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      max_q <= '0;
    end else if (fs) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      max_q <= nl_en ? new_label_value : '0;
    end else begin
      if (mg_ok && f_full) ovf_q <= 1'b1;
      if (busy_q && in_any) err_q <= 1'b1;
      if (nl_en && (new_label_value > max_q))
        max_q <= new_label_value;
    end
  end

  assign resolve_busy      = busy_q;
  assign resolve_done      = done_q;
  assign lookup_root_valid = lv_q;
  assign lookup_root       = lr_q;
  assign overflow          = ovf_q;
  assign error             = err_q;

endmodule

// File: tb/tb_label_equiv_table.sv
// Directed self-checking bench for label_equiv_table.
module tb_label_equiv_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       new_label_valid = 1'b0;
  logic [7:0] new_label_value = '0;
  logic       merge_labels = 1'b0;
  logic [7:0] merge_a = '0;
  logic [7:0] merge_b = '0;
  logic       last_in_frame = 1'b0;
  logic       resolve_busy, resolve_done;
  logic       lookup_valid = 1'b0;
  logic [7:0] lookup_label = '0;
  logic       lookup_root_valid;
  logic [7:0] lookup_root;
  logic       overflow, error;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  label_equiv_table dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .new_label_valid   (new_label_valid),
    .new_label_value   (new_label_value),
    .merge_labels      (merge_labels),
    .merge_a           (merge_a),
    .merge_b           (merge_b),
    .last_in_frame     (last_in_frame),
    .resolve_busy      (resolve_busy),
    .resolve_done      (resolve_done),
    .lookup_valid      (lookup_valid),
    .lookup_label      (lookup_label),
    .lookup_root_valid (lookup_root_valid),
    .lookup_root       (lookup_root),
    .overflow          (overflow),
    .error             (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic alloc(input int v);
    new_label_valid = 1'b1;
    new_label_value = 8'(v);
    tick();
    new_label_valid = 1'b0;
  endtask

  task automatic merge(input int a, input int b);
    merge_labels = 1'b1;
    merge_a = 8'(a);
    merge_b = 8'(b);
    tick();
    merge_labels = 1'b0;
  endtask

  task automatic kick_resolve();
    last_in_frame = 1'b1;
    tick();
    last_in_frame = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (resolve_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic lookup(input int v, output logic vld,
                        output logic [7:0] r);
    lookup_valid = 1'b1;
    lookup_label = 8'(v);
    tick();
    vld = lookup_root_valid;
    r = lookup_root;
    lookup_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    logic vld;
    logic [7:0] r;
    #12;
    outs = {resolve_busy, resolve_done, lookup_root_valid,
            lookup_root, overflow, error};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_init got=%h exp=0", outs);
    end
    #10 rst = 1'b1;
    tick();
    alloc(1); alloc(2);
    merge(2, 1);
    kick_resolve();
    lookup_valid = 1'b1;
    lookup_label = 8'd2;
    tick();
    lookup_valid = 1'b0;
    tests_run++;
    if ({resolve_busy, error} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_pre busy,err got=%b exp=11",
               {resolve_busy, error});
    end
    #2 rst = 1'b0;
    #1;
    outs = {resolve_busy, resolve_done, lookup_root_valid,
            lookup_root, overflow, error};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_async got=%h exp=0", outs);
    end
    #2 rst = 1'b1;
    tick();
    lookup(2, vld, r);
    tests_run++;
    if ({vld, r} !== {1'b1, 8'd2}) begin
      tests_failed++;
      $display("FAIL reset_table got=%b/%0d exp=1/2", vld, r);
    end
  endtask

  task automatic test_chain();
    bit ok;
    logic vld;
    logic [7:0] r;
    new_frame();
    alloc(1); alloc(2); alloc(3);
    merge(2, 1); merge(3, 2);
    kick_resolve();
    tests_run++;
    if (resolve_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL chain_busy got=%b exp=1", resolve_busy);
    end
    wait_done(ok);
    tests_run++;
    if (!ok || resolve_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL chain_done ok=%b busy=%b exp 1/0",
               ok, resolve_busy);
    end
    tick();
    tests_run++;
    if (resolve_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL chain_pulse got=%b exp=0", resolve_done);
    end
    for (int l = 1; l <= 3; l++) begin
      lookup(l, vld, r);
      tests_run++;
      if ({vld, r} !== {1'b1, 8'd1}) begin
        tests_failed++;
        $display("FAIL chain_lookup %0d got=%b/%0d exp=1/1",
                 l, vld, r);
      end
    end
    tick();
    tests_run++;
    if (lookup_root_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL lookup_valid_drop got=%b exp=0",
               lookup_root_valid);
    end
  endtask

  task automatic test_deferred();
    bit ok;
    logic vld;
    logic [7:0] r;
    int lbl [4] = '{4, 5, 2, 3};
    int exp [4] = '{3, 3, 1, 3};
    new_frame();
    for (int l = 1; l <= 5; l++) alloc(l);
    merge(5, 3); merge(5, 4); merge(2, 1);
    kick_resolve();
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL deferred_done got=0 exp=1");
    end
    for (int k = 0; k < 4; k++) begin
      lookup(lbl[k], vld, r);
      tests_run++;
      if ({vld, r} !== {1'b1, 8'(exp[k])}) begin
        tests_failed++;
        $display("FAIL deferred_lookup %0d got=%b/%0d exp=1/%0d",
                 lbl[k], vld, r, exp[k]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic vld;
    logic [7:0] r;
    int lbl [5] = '{5, 10, 11, 20, 30};
    int exp [5] = '{1, 1, 1, 1, 30};
    new_frame();
    for (int l = 1; l <= 30; l++) alloc(l);
    for (int k = 9; k >= 1; k--) merge(k, k + 1);
    wait_cycles(100);
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_pre got=%b exp=0", overflow);
    end
    for (int k = 11; k <= 30; k++) merge(k, 10);
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set got=%b exp=1", overflow);
    end
    kick_resolve();
    wait_done(ok);
    tests_run++;
    if (!ok || error !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_done ok=%b err=%b exp 1/0", ok, error);
    end
    for (int k = 0; k < 5; k++) begin
      lookup(lbl[k], vld, r);
      tests_run++;
      if ({vld, r} !== {1'b1, 8'(exp[k])}) begin
        tests_failed++;
        $display("FAIL ovf_lookup %0d got=%b/%0d exp=1/%0d",
                 lbl[k], vld, r, exp[k]);
      end
    end
  endtask

  task automatic test_trivial();
    bit ok;
    logic vld;
    logic [7:0] r;
    int lbl [3] = '{7, 4, 0};
    new_frame();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL trivial_ovf_clr got=%b exp=0", overflow);
    end
    alloc(4); alloc(7);
    merge(7, 7); merge(0, 4);
    kick_resolve();
    wait_done(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL trivial_done got=0 exp=1");
    end
    for (int k = 0; k < 3; k++) begin
      lookup(lbl[k], vld, r);
      tests_run++;
      if ({vld, r} !== {1'b1, 8'(lbl[k])}) begin
        tests_failed++;
        $display("FAIL trivial_lookup %0d got=%b/%0d exp=1/%0d",
                 lbl[k], vld, r, lbl[k]);
      end
    end
  endtask

  task automatic test_busy();
    bit ok;
    logic vld;
    logic [7:0] r;
    new_frame();
    alloc(1); alloc(2); alloc(3);
    merge(2, 1); merge(3, 2);
    wait_cycles(30);
    kick_resolve();
    tick();
    new_label_valid = 1'b1;
    new_label_value = 8'd3;
    tick();
    new_label_valid = 1'b0;
    wait_done(ok);
    tests_run++;
    if (!ok || error !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_err ok=%b err=%b exp 1/1", ok, error);
    end
    lookup(3, vld, r);
    tests_run++;
    if ({vld, r} !== {1'b1, 8'd1}) begin
      tests_failed++;
      $display("FAIL busy_table got=%b/%0d exp=1/1", vld, r);
    end
    new_frame();
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_err_clr got=%b exp=0", error);
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_deferred();
    test_overflow();
    test_trivial();
    test_busy();
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/label_equiv_table.md
# label_equiv_table

Equivalence (union-find) table for the connected-component labeling stage. It sits directly downstream of the labeler and consumes its new-label and merge outputs during a frame. At frame end it resolves every label to its minimum-valued root. It then serves single-cycle-latency root lookups to the bounding-box accumulation stage.

## Interface
- LABEL_WIDTH, 8, label width; label 0 is background and never allocated.
- NUM_LABELS, 2**LABEL_WIDTH, table entries.
- MERGE_FIFO_DEPTH, 16, merge request buffer depth (power of 2).

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  pulse; clears max_label, FIFO, overflow, error
- new_label_valid  in  1  labeler allocated a label
- new_label_value  in  LABEL_WIDTH  allocated label
- merge_labels  in  1  labeler found equivalence
- merge_a, merge_b  in  LABEL_WIDTH  equivalent labels
- last_in_frame  in  1  pulse; requests resolve
- resolve_busy  out  1  high from accepted last_in_frame until resolve_done
- resolve_done  out  1  one-cycle pulse; table flattened
- lookup_valid  in  1  lookup request (legal only when !resolve_busy)
- lookup_label  in  LABEL_WIDTH  label to resolve
- lookup_root_valid  out  1  registered lookup_valid
- lookup_root  out  LABEL_WIDTH  root of lookup_label
- overflow  out  1  sticky; merge dropped on full FIFO
- error  out  1  sticky; input arrived while resolve_busy

## Operation
- Storage: parent[NUM_LABELS] register array. Invariant: parent[i] <= i.
- new_label_valid: parent[v] <= v; max_label <= max(max_label, v). Not buffered. Wins over an engine write to the same index.
- merge_labels: dropped if merge_a==merge_b or either is 0. Otherwise {a,b} is pushed to merge_fifo. If the FIFO is full: dropped, overflow<=1.
- Engine FSM states: IDLE, FIND_A, FIND_B, LINK, FLATTEN, DONE.
  - IDLE: if FIFO non-empty, pop into x=a, y=b, go FIND_A. Else if resolve_pending, go FLATTEN with i=1.
  - FIND_A: if parent[x]==x go FIND_B; else x<=parent[x].
  - FIND_B: same walk on y; at root go LINK.
  - LINK: if x!=y, parent[max(x,y)] <= min(x,y). Go IDLE.
  - FLATTEN: parent[i] <= parent[parent[i]]; i++. After i==max_label go DONE. If max_label==0, go DONE immediately.
  - DONE: resolve_done=1 for one cycle; clear resolve_pending; go IDLE.
- Ascending-order flatten with parent[i]<=i gives every entry its root in a single pass.
- last_in_frame sets resolve_pending and resolve_busy. The FIFO drains fully before FLATTEN begins.
- While resolve_busy: new_label_valid, merge_labels, last_in_frame and lookup_valid are ignored; error<=1.
- Lookup: lookup_root <= parent[lookup_label] registered. Label 0 returns 0.
- frame_start while busy: ignored, error<=1.

## Timing
- Reset values: resolve_busy=0, resolve_done=0, lookup_root_valid=0, lookup_root=0, overflow=0, error=0, all FSM state IDLE, parent[i]=i, max_label=0, FIFO empty.
- Merge service: 1 (pop) + depth_a + depth_b + 1 (link) cycles; the FIFO absorbs bursts.
- Resolve latency: FIFO drain time + max_label + 2 cycles from last_in_frame to resolve_done.
- Lookup latency: 1 cycle.
- new_label_valid and merge_labels in the same cycle are both accepted.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Structure
- Package labeler_pkg: LABEL_WIDTH, label_t typedef, engine state enum.
- Sub-module merge_fifo: synchronous FIFO with full/empty flags, width 2*LABEL_WIDTH, depth MERGE_FIFO_DEPTH.
- Top-level: parent array, FSM, lookup register.

## Test plan
- Reset: assert rst=0 mid-traffic -> every output is 0 and busy is low in the same cycle.
- Chain: new labels 1,2,3; merge(2,1), merge(3,2); last_in_frame -> resolve_done pulses; lookups 1,2,3 all return 1 one cycle later.
- Deferred link: labels 1..5; merge(5,3), merge(5,4), merge(2,1) -> lookups 4→3, 5→3, 2→1, 3→3.
- Overflow: 20 back-to-back merges forming a deep chain -> overflow=1; the resolve still completes and accepted merges resolve correctly.
- Trivial inputs: merge(7,7), merge(0,4), lookup 0 -> no FIFO push, 0 returned.
- Busy protection: new_label_valid during FLATTEN -> error=1 and table unchanged. frame_start then clears error.
